// File: rtl/fft_stream_pkg.sv
// Shared types and helpers for the FFT bin streaming blocks.
package fft_stream_pkg;

    typedef enum logic {
        IDLE,
        STREAM
    } stream_state_t;

    // Working width for magnitude helpers; covers any sample_size up to 63 bits.
    localparam int ABS_W = 64;

    // Width of a bin index for a frame of the given number of points.
    function automatic int index_width(input int points);
        return $clog2(points);
    endfunction

    // Absolute value of a sign-extended sample. The result is one bit wider than the
    // original sample in practice, so the most negative value maps exactly, without saturation.
    function automatic logic [ABS_W-1:0] abs_ext(input logic signed [ABS_W-1:0] value);
        return value[ABS_W-1] ? $unsigned(-value) : $unsigned(value);
    endfunction

endpackage

// File: rtl/fft_bin_mag.sv
// Combinational L1 magnitude |re|+|im| of one complex bin, one bit wider than a sample.
module fft_bin_mag
    import fft_stream_pkg::*;
#(
    parameter int sample_size = 32
) (
    input  logic [sample_size-1:0] re,
    input  logic [sample_size-1:0] im,
    output logic [sample_size:0]   mag
);

    logic [sample_size:0] re_abs;
    logic [sample_size:0] im_abs;

    // Sign-extend each part, take its magnitude, then add in sample_size+1 bits.
    always_comb begin
        re_abs = (sample_size+1)'(abs_ext(ABS_W'($signed(re))));
        im_abs = (sample_size+1)'(abs_ext(ABS_W'($signed(im))));
        mag    = re_abs + im_abs;
    end

endmodule

// File: rtl/fft_bin_streamer.sv
// Captures one parallel FFT frame and streams its bins out one beat at a time.
module fft_bin_streamer
    import fft_stream_pkg::*;
#(
    parameter int sample_size   = 32,
    parameter int buffer_size   = 32,
    parameter bit half_spectrum = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_valid,
    output logic                              frame_ready,
    input  logic [buffer_size*sample_size-1:0] frame_real,
    input  logic [buffer_size*sample_size-1:0] frame_imag,
    output logic                              bin_valid,
    input  logic                              bin_ready,
    output logic [sample_size-1:0]            bin_real,
    output logic [sample_size-1:0]            bin_imag,
    output logic [$clog2(buffer_size)-1:0]    bin_index,
    output logic [sample_size:0]              bin_mag,
    output logic                              bin_last,
    output logic                              busy
);

    localparam int IW       = index_width(buffer_size);
    localparam int FW       = buffer_size * sample_size;
    localparam int LAST_INT = half_spectrum ? buffer_size / 2 : buffer_size - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LAST_INT);

    stream_state_t state;
    stream_state_t state_next;
    logic [FW-1:0] re_q;
    logic [FW-1:0] im_q;
    logic [IW-1:0] idx;
    logic          xfer;
    logic          take;
    logic          at_last;

    // Handshake decode; a new frame may land in the same cycle the last beat leaves.
    always_comb begin
        bin_valid   = (state == STREAM);
        busy        = (state == STREAM);
        at_last     = (idx == LAST_IDX);
        bin_last    = bin_valid && at_last;
        xfer        = bin_valid && bin_ready;
        frame_ready = (state == IDLE) || (xfer && bin_last);
        take        = frame_valid && frame_ready;
    end

    // Next-state logic: leave STREAM only when the last beat goes without a follow-on frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = STREAM;
            STREAM:  if (xfer && bin_last && !take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Frame capture and bin index walk; the index stops at the last bin and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_q <= '0;
            im_q <= '0;
            idx  <= '0;
        end else if (take) begin
            re_q <= frame_real;
            im_q <= frame_imag;
            idx  <= '0;
        end else if (xfer && !at_last) begin
            idx <= idx + 1'b1;
        end
    end

    // Select the current bin from the held frame; outputs read zero when idle.
    always_comb begin
        bin_index = bin_valid ? idx : '0;
        bin_real  = bin_valid ? re_q[int'(idx)*sample_size +: sample_size] : '0;
        bin_imag  = bin_valid ? im_q[int'(idx)*sample_size +: sample_size] : '0;
    end

    fft_bin_mag #(
        .sample_size(sample_size)
    ) u_mag (
        .re (bin_real),
        .im (bin_imag),
        .mag(bin_mag)
    );

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Randomized bench for fft_bin_streamer: an 8-point full-spectrum instance and a
// 32-point half-spectrum instance, both checked against a queue of expected beats.
module tb_fft_bin_streamer;

    typedef struct {
        int          idx;
        logic [31:0] re;
        logic [31:0] im;
        logic [32:0] mag;
        bit          last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        fv [2];
    logic        br [2];
    logic [31:0] fre [2][32];
    logic [31:0] fim [2][32];
    int          readyMode [2];
    int          lastIdx [2];
    int          readyCnt;
    beat_t       expq [2][$];
    int          total;
    int          errors;

    logic [8*32-1:0]  f0re, f0im;
    logic [32*32-1:0] f1re, f1im;

    logic        fr0, v0, last0, busy0;
    logic [31:0] re0, im0;
    logic [32:0] mag0;
    logic [2:0]  idx0;

    logic        fr1, v1, last1, busy1;
    logic [31:0] re1, im1;
    logic [32:0] mag1;
    logic [4:0]  idx1;

    fft_bin_streamer #(.sample_size(32), .buffer_size(8), .half_spectrum(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .frame_valid(fv[0]), .frame_ready(fr0),
        .frame_real(f0re), .frame_imag(f0im),
        .bin_valid(v0), .bin_ready(br[0]),
        .bin_real(re0), .bin_imag(im0), .bin_index(idx0),
        .bin_mag(mag0), .bin_last(last0), .busy(busy0)
    );

    fft_bin_streamer #(.sample_size(32), .buffer_size(32), .half_spectrum(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .frame_valid(fv[1]), .frame_ready(fr1),
        .frame_real(f1re), .frame_imag(f1im),
        .bin_valid(v1), .bin_ready(br[1]),
        .bin_real(re1), .bin_imag(im1), .bin_index(idx1),
        .bin_mag(mag1), .bin_last(last1), .busy(busy1)
    );

    // Pack the per-bin stimulus arrays onto the flat frame buses.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            f0re[k*32 +: 32] = fre[0][k];
            f0im[k*32 +: 32] = fim[0][k];
        end
        for (int k = 0; k < 32; k++) begin
            f1re[k*32 +: 32] = fre[1][k];
            f1im[k*32 +: 32] = fim[1][k];
        end
    end

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference magnitude with plain integer arithmetic.
    function automatic logic [32:0] refMag(input logic [31:0] r, input logic [31:0] i);
        longint ar;
        longint ai;
        ar = longint'($signed(r));
        ai = longint'($signed(i));
        if (ar < 0) ar = -ar;
        if (ai < 0) ai = -ai;
        return 33'(ar + ai);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare one instance against the expected beat queue, then advance the model.
    task automatic monitorStep(input int d, input logic bv, input logic fr, input logic bs,
                               input logic bl, input logic [31:0] re, input logic [31:0] im,
                               input logic [32:0] mag, input int idx);
        beat_t b;
        bit    expValid;
        bit    expReady;
        string p;
        p        = (d == 0) ? "n8" : "n32h";
        expValid = (expq[d].size() != 0);
        expReady = 1'b1;
        checkOutput({p, ".bin_valid"}, 64'(bv), 64'(expValid));
        checkOutput({p, ".busy"}, 64'(bs), 64'(expValid));
        if (expValid) begin
            b = expq[d][0];
            checkOutput({p, ".bin_index"}, 64'(idx), 64'(b.idx));
            checkOutput({p, ".bin_real"}, 64'(re), 64'(b.re));
            checkOutput({p, ".bin_imag"}, 64'(im), 64'(b.im));
            checkOutput({p, ".bin_mag"}, 64'(mag), 64'(b.mag));
            checkOutput({p, ".bin_last"}, 64'(bl), 64'(b.last));
            expReady = br[d] && b.last;
        end
        checkOutput({p, ".frame_ready"}, 64'(fr), 64'(expReady));
        if (expValid && br[d]) void'(expq[d].pop_front());
        if (fv[d] && expReady) begin
            for (int k = 0; k <= lastIdx[d]; k++) begin
                b.idx  = k;
                b.re   = fre[d][k];
                b.im   = fim[d][k];
                b.mag  = refMag(fre[d][k], fim[d][k]);
                b.last = (k == lastIdx[d]);
                expq[d].push_back(b);
            end
        end
    endtask

    // Monitor both instances on every falling edge while out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                monitorStep(0, v0, fr0, busy0, last0, re0, im0, mag0, int'(idx0));
                monitorStep(1, v1, fr1, busy1, last1, re1, im1, mag1, int'(idx1));
            end
        end
    end

    // Consumer ready driver: always, a 1,0,0 stall pattern, or random.
    initial begin
        readyCnt = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                case (readyMode[d])
                    0:       br[d] = 1'b1;
                    1:       br[d] = (readyCnt % 3 == 0);
                    default: br[d] = 1'($urandom_range(0, 1));
                endcase
            end
            readyCnt++;
        end
    end

    // Load a frame and hold frame_valid until the instance accepts it.
    task automatic applyStimulus(input int d, input int kind);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 32; k++) begin
            case (kind)
                0: begin
                    fre[d][k] = 32'(k * 10);
                    fim[d][k] = 32'(-k);
                end
                default: begin
                    fre[d][k] = $urandom;
                    fim[d][k] = $urandom;
                end
            endcase
        end
        if (kind == 2) begin
            fre[d][3] = 32'h8000_0000;
            fim[d][3] = 32'h8000_0000;
        end
        fv[d] = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if ((d == 0) ? fr0 : fr1) done = 1'b1;
        end
        if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input int d);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 600 && !idle; c++) begin
            @(negedge clk);
            if (expq[d].size() == 0) idle = 1'b1;
        end
        if (!idle) checkOutput("idle_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string p, input logic bv, input logic bl, input logic bs,
                              input logic [31:0] re, input logic [31:0] im,
                              input logic [32:0] mag, input int idx);
        checkOutput({p, ".rst.bin_valid"}, 64'(bv), 64'd0);
        checkOutput({p, ".rst.bin_last"}, 64'(bl), 64'd0);
        checkOutput({p, ".rst.busy"}, 64'(bs), 64'd0);
        checkOutput({p, ".rst.bin_real"}, 64'(re), 64'd0);
        checkOutput({p, ".rst.bin_imag"}, 64'(im), 64'd0);
        checkOutput({p, ".rst.bin_mag"}, 64'(mag), 64'd0);
        checkOutput({p, ".rst.bin_index"}, 64'(idx), 64'd0);
    endtask

    // Bound the whole run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        bit found;
        total        = 0;
        errors       = 0;
        lastIdx[0]   = 7;
        lastIdx[1]   = 16;
        readyMode[0] = 0;
        readyMode[1] = 0;
        fv[0] = 1'b0;
        fv[1] = 1'b0;
        br[0] = 1'b1;
        br[1] = 1'b1;
        for (int k = 0; k < 32; k++) begin
            fre[0][k] = '0; fim[0][k] = '0;
            fre[1][k] = '0; fim[1][k] = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkReset("n8", v0, last0, busy0, re0, im0, mag0, int'(idx0));
        checkReset("n32h", v1, last1, busy1, re1, im1, mag1, int'(idx1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] ramp frame, ready held high");
        applyStimulus(0, 0);
        fv[0] = 1'b0;
        waitIdle(0);

        $display("[TB] ramp frame with 1,0,0 stalls");
        readyMode[0] = 1;
        applyStimulus(0, 0);
        fv[0] = 1'b0;
        waitIdle(0);

        $display("[TB] most-negative magnitude");
        readyMode[0] = 0;
        applyStimulus(0, 2);
        fv[0] = 1'b0;
        waitIdle(0);

        $display("[TB] back-to-back frames");
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        readyMode[0] = 2;
        applyStimulus(0, 1);
        applyStimulus(0, 2);
        fv[0] = 1'b0;
        waitIdle(0);

        $display("[TB] half spectrum, 32 points");
        applyStimulus(1, 1);
        fv[1] = 1'b0;
        waitIdle(1);
        readyMode[1] = 2;
        applyStimulus(1, 1);
        applyStimulus(1, 2);
        fv[1] = 1'b0;
        waitIdle(1);

        $display("[TB] random traffic");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                fv[0] = 1'b0;
                repeat ($urandom_range(0, 12)) @(posedge clk);
                #1;
            end
        end
        fv[0] = 1'b0;
        waitIdle(0);

        $display("[TB] reset in mid-frame");
        readyMode[0] = 0;
        applyStimulus(0, 0);
        fv[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (expq[0].size() != 0 && expq[0][0].idx == 5) found = 1'b1;
        end
        if (!found) checkOutput("index5_timeout", 64'd0, 64'd1);
        #1 rst_n = 1'b0;
        expq[0].delete();
        expq[1].delete();
        #1;
        checkReset("n8", v0, last0, busy0, re0, im0, mag0, int'(idx0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(0, 1);
        fv[0] = 1'b0;
        waitIdle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errors);
        $finish;
    end

endmodule

// File: doc/fft_bin_streamer.md
Name: fft_bin_streamer

Overview:
- Consumer end of the FFT_N_Point output interface: captures the flat `output_real`/`output_imag` buses for one frame and streams the bins out one per beat over a valid/ready handshake.
- Each beat carries the bin index, last flag and an L1 magnitude, for downstream spectrum display and band logic.
- Sits between FFT_N_Point and any serial consumer, decoupling the wide parallel frame from a narrow datapath.

Parameters:
- `sample_size`, 32, width of each signed real/imag bin word (matches FFT_N_Point `sample_size`).
- `buffer_size`, 32, number of FFT points N per frame; power of two, >= 2.
- `half_spectrum`, 0, if 1 stream only bins 0..N/2 (real-input symmetry); if 0 stream bins 0..N-1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `frame_valid`  in  1  `frame_real`/`frame_imag` hold a complete FFT frame.
- `frame_ready`  out  1  streamer can accept a frame this cycle.
- `frame_real`  in  buffer_size*sample_size  signed bins, bin k at [k*sample_size +: sample_size].
- `frame_imag`  in  buffer_size*sample_size  signed bins, same packing.
- `bin_valid`  out  1  output beat valid.
- `bin_ready`  in  1  consumer accepts beat.
- `bin_real`  out  sample_size  signed real part of current bin.
- `bin_imag`  out  sample_size  signed imag part of current bin.
- `bin_index`  out  $clog2(buffer_size)  index k of current bin.
- `bin_mag`  out  sample_size+1  unsigned |re|+|im| of current bin.
- `bin_last`  out  1  current beat is the final bin of the frame.
- `busy`  out  1  a frame is held, not yet fully streamed.

Behaviour:
- Reset (async, `rst_n`=0):
  - State → IDLE.
  - `bin_valid`, `bin_last`, `busy` = 0.
  - `bin_real`, `bin_imag`, `bin_index`, `bin_mag` = 0.
  - Frame registers cleared.
  - Reset mid-frame discards the frame; no partial resume.
- States:
  - IDLE: `frame_ready`=1, `bin_valid`=0. On `frame_valid`&&`frame_ready`, register both buses, index←0, → STREAM.
  - STREAM: `bin_valid`=1, `busy`=1, outputs reflect bin[index].
- Latency:
  - Frame accepted at edge T → first beat (index 0) valid from T+1.
  - Each beat is one cycle when `bin_ready` is held high.
  - A full frame takes `last_idx`+1 cycles, where `last_idx` = N-1, or N/2 if `half_spectrum`.
- Handshake:
  - Beat transfers on `bin_valid`&&`bin_ready`.
  - While `bin_valid`&&!`bin_ready`, all bin outputs hold stable.
  - `bin_valid` never drops without a transfer, except on reset.
- Index advance:
  - On transfer with index < `last_idx`, index += 1.
  - On transfer with index == `last_idx`:
    - if `frame_valid` is high the same cycle, capture the new frame, index←0, stay in STREAM (back-to-back, no bubble);
    - otherwise → IDLE.
  - Index never wraps past `last_idx`.
- `frame_ready` = (state==IDLE) || (`bin_valid` && `bin_ready` && `bin_last`). This combinational path from `bin_ready` is intentional.
- `frame_valid` while not ready is ignored; the frame must be held by the producer.
- `bin_last` = (index == `last_idx`) in STREAM.
- `bin_real`/`bin_imag`/`bin_mag`/`bin_last` are muxed from the captured registers by the index register. Registered index means no combinational path from `frame_*` to the outputs.
- Magnitude arithmetic:
  - `bin_mag` = |re| + |im|, computed in sample_size+1 unsigned.
  - |most-negative| = 2^(sample_size-1), exact with no saturation.
  - Maximum value 2^sample_size fits.
- `busy` = (state==STREAM).

Decomposition:
- Package `fft_stream_pkg`:
  - state enum `{IDLE, STREAM}`;
  - function `abs_ext(signed [sample_size-1:0]) → unsigned [sample_size:0]`;
  - localparam helper for index width `$clog2(buffer_size)`.
- One sub-module `fft_bin_mag`: combinational |re|+|im| on the selected bin, reused by later band-energy blocks.

Test Plan:
- N=8, `half_spectrum`=0, frame re[k]=k·10, im[k]=-k; `bin_ready`=1 → 8 beats on consecutive cycles, index 0..7, `bin_real`=0,10..70, `bin_mag`=0,11,..,77, `bin_last` only at index 7, then IDLE, `frame_ready`=1.
- Same frame, `bin_ready` toggled 1,0,0,1,... → outputs stable across stalls, no bins skipped or duplicated, all 8 beats in order.
- Bin 3 re=-2^31, im=-2^31 (sample_size 32) → `bin_mag`=2^32 (33-bit 0x1_0000_0000), `bin_real`=0x8000_0000.
- `half_spectrum`=1, N=32 → 17 beats, `bin_last` at index 16, index never exceeds 16.
- Second frame presented with `frame_valid` high during the last beat's transfer → `frame_ready`=1 that cycle; next cycle index 0 of frame 2 with no idle bubble.
- `rst_n` pulled low mid-frame at index 5 → all outputs 0 immediately (async); after release IDLE, `frame_ready`=1, the old frame is never resumed.
